// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter sharing the qspi_flash read port between two requesters.
// Optional one-entry read cache enabled by defining FLASH_ARB_CACHE_EN.
module flash_read_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req_valid,
   input  logic [23:0] a_req_addr,
   output logic        a_req_ready,
   output logic        a_rsp_valid,
   input  logic        b_req_valid,
   input  logic [23:0] b_req_addr,
   output logic        b_req_ready,
   output logic        b_rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [23:0] flash_addr,
   output logic        flash_do_read,
   input  logic        flash_setup_done,
   input  logic        flash_data_ready,
   input  logic [7:0]  flash_data
);
   typedef enum logic [1:0] {SETUP, IDLE, ISSUE, RESP} state_t;
   state_t      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        err_q, err_d;
   logic        gnt_b_q, gnt_b_d;
   logic        last_b_q, last_b_d;
   logic [15:0] cnt_q, cnt_d;
   logic        busy_q;
   logic        sel_b, grant, hit;
   logic [23:0] sel_addr;
   logic [7:0]  hit_data;
   assign sel_b    = b_req_valid && (!a_req_valid || !last_b_q);
   assign sel_addr = sel_b ? b_req_addr : a_req_addr;
   assign grant    = state_q == IDLE && flash_setup_done && (a_req_valid || b_req_valid);
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = err_q;
      gnt_b_d  = gnt_b_q;
      last_b_d = last_b_q;
      cnt_d    = cnt_q;
      case (state_q)
         SETUP: state_d = flash_setup_done ? IDLE : SETUP;
         IDLE: begin
            if (!flash_setup_done) state_d = SETUP;
            else if (grant) begin
               addr_d   = sel_addr;
               gnt_b_d  = sel_b;
               last_b_d = sel_b;
               cnt_d    = '0;
               err_d    = 1'b0;
               data_d   = hit_data;
               state_d  = hit ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 16'd1;
            // data beats both timeout and a lost setup_done in the same cycle
            if (flash_data_ready) begin
               data_d  = flash_data;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (!flash_setup_done || cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               data_d  = 8'hFF;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: state_d = flash_setup_done ? IDLE : SETUP;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SETUP;
         addr_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         gnt_b_q  <= 1'b0;
         last_b_q <= 1'b1;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         err_q    <= err_d;
         gnt_b_q  <= gnt_b_d;
         last_b_q <= last_b_d;
         cnt_q    <= cnt_d;
         busy_q   <= state_d != IDLE;
      end
   end
`ifdef FLASH_ARB_CACHE_EN
   logic        cv_q, cv_d;
   logic [23:0] ca_q, ca_d;
   logic [7:0]  cd_q, cd_d;
   assign hit      = cv_q && ca_q == sel_addr;
   assign hit_data = cd_q;
   always_comb begin
      cv_d = cv_q;
      ca_d = ca_q;
      cd_d = cd_q;
      if (state_q == ISSUE && state_d == RESP) begin
         cv_d = !err_d;
         ca_d = err_d ? ca_q : addr_q;
         cd_d = err_d ? cd_q : flash_data;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cv_q <= 1'b0;
         ca_q <= '0;
         cd_q <= '0;
      end else begin
         cv_q <= cv_d;
         ca_q <= ca_d;
         cd_q <= cd_d;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = 8'h00;
`endif
   assign a_req_ready   = grant && !sel_b;
   assign b_req_ready   = grant && sel_b;
   assign a_rsp_valid   = state_q == RESP && !gnt_b_q;
   assign b_rsp_valid   = state_q == RESP && gnt_b_q;
   assign rsp_data      = state_q == RESP ? data_q : 8'h00;
   assign rsp_err       = state_q == RESP && err_q;
   assign flash_do_read = state_q == ISSUE;
   assign flash_addr    = flash_do_read ? addr_q : 24'h0;
   assign busy          = busy_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed scenario bench for flash_read_arbiter with an 8-cycle timeout.
module tb_flash_read_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic [23:0] a_req_addr = '0, b_req_addr = '0;
   logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err, busy, flash_do_read;
   logic [23:0] flash_addr;
   logic        flash_setup_done = 1'b0, flash_data_ready = 1'b0;
   logic [7:0]  flash_data = '0;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   flash_read_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_addr(a_req_addr), .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
      .b_req_valid(b_req_valid), .b_req_addr(b_req_addr), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .flash_addr(flash_addr), .flash_do_read(flash_do_read),
      .flash_setup_done(flash_setup_done), .flash_data_ready(flash_data_ready), .flash_data(flash_data)
   );

   task automatic finish_read(input logic [7:0] d);
      flash_data = d;
      flash_data_ready = 1'b1;
      @(negedge clk);
      flash_data_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, flash_do_read, busy, rsp_err, rsp_data, flash_addr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, flash_do_read, busy, rsp_err, rsp_data, flash_addr});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL setup_busy: got %b expected 1", busy); end
   endtask

   task automatic test_setup_and_read;
      a_req_valid = 1'b1; a_req_addr = 24'h000010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (a_req_ready !== 1'b0) begin errors++; $display("FAIL setup_block: got %b expected 0", a_req_ready); end
      end
      flash_setup_done = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (a_req_ready !== 1'b1) begin errors++; $display("FAIL setup_ready: got %b expected 1", a_req_ready); end
      @(negedge clk);
      a_req_valid = 1'b0;
      checks++;
      if (flash_do_read !== 1'b1 || flash_addr !== 24'h000010) begin
         errors++; $display("FAIL issue_addr: got do_read=%b addr=%h expected 1/000010", flash_do_read, flash_addr);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (flash_do_read !== 1'b1) begin errors++; $display("FAIL do_read_held: got %b expected 1", flash_do_read); end
      finish_read(8'h5A);
      checks++;
      if ({a_rsp_valid, b_rsp_valid, rsp_err, rsp_data, flash_do_read} !== {1'b1, 1'b0, 1'b0, 8'h5A, 1'b0}) begin
         errors++; $display("FAIL first_rsp: got a=%b b=%b err=%b data=%h dr=%b expected 1 0 0 5a 0", a_rsp_valid, b_rsp_valid, rsp_err, rsp_data, flash_do_read);
      end
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle: got rsp=%b busy=%b expected 0 0", a_rsp_valid, busy); end
   endtask

   task automatic test_round_robin;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      a_req_valid = 1'b1; a_req_addr = 24'h000100;
      b_req_valid = 1'b1; b_req_addr = 24'h000200;
      #1;
      checks++;
      if ({a_req_ready, b_req_ready} !== 2'b10) begin errors++; $display("FAIL rr_first: got %b expected 10", {a_req_ready, b_req_ready}); end
      @(negedge clk);
      a_req_valid = 1'b0; #1;
      checks++;
      if (flash_addr !== 24'h000100 || b_req_ready !== 1'b0) begin errors++; $display("FAIL rr_addr1: got %h/%b expected 000100/0", flash_addr, b_req_ready); end
      finish_read(8'h11);
      checks++;
      if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0 || rsp_data !== 8'h11) begin errors++; $display("FAIL rr_rsp1: got %b%b %h expected 10 11", a_rsp_valid, b_rsp_valid, rsp_data); end
      a_req_valid = 1'b1; a_req_addr = 24'h000300;
      @(negedge clk); #1;
      checks++;
      if ({a_req_ready, b_req_ready} !== 2'b01) begin errors++; $display("FAIL rr_second: got %b expected 01", {a_req_ready, b_req_ready}); end
      @(negedge clk);
      b_req_valid = 1'b0; #1;
      checks++;
      if (flash_addr !== 24'h000200) begin errors++; $display("FAIL rr_addr2: got %h expected 000200", flash_addr); end
      finish_read(8'h22);
      checks++;
      if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || rsp_data !== 8'h22) begin errors++; $display("FAIL rr_rsp2: got %b%b %h expected 01 22", a_rsp_valid, b_rsp_valid, rsp_data); end
      @(negedge clk); #1;
      checks++;
      if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rr_third: got %b expected 1", a_req_ready); end
      @(negedge clk);
      a_req_valid = 1'b0; #1;
      checks++;
      if (flash_addr !== 24'h000300) begin errors++; $display("FAIL rr_addr3: got %h expected 000300", flash_addr); end
      finish_read(8'h33);
      checks++;
      if (a_rsp_valid !== 1'b1 || rsp_data !== 8'h33) begin errors++; $display("FAIL rr_rsp3: got %b %h expected 1 33", a_rsp_valid, rsp_data); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int n;
      a_req_valid = 1'b1; a_req_addr = 24'h000400;
      #1;
      checks++;
      if (a_req_ready !== 1'b1) begin errors++; $display("FAIL to_grant: got %b expected 1", a_req_ready); end
      @(negedge clk);
      a_req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && flash_do_read === 1'b1; i++) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 8) begin errors++; $display("FAIL to_cycles: got %0d expected 8", n); end
      checks++;
      if ({a_rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'hFF}) begin errors++; $display("FAIL to_rsp: got %b %b %h expected 1 1 ff", a_rsp_valid, rsp_err, rsp_data); end
      @(negedge clk);
      a_req_valid = 1'b1; a_req_addr = 24'h000500;
      @(negedge clk);
      a_req_valid = 1'b0;
      finish_read(8'h77);
      checks++;
      if ({a_rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h77}) begin errors++; $display("FAIL to_recover: got %b %b %h expected 1 0 77", a_rsp_valid, rsp_err, rsp_data); end
      @(negedge clk);
   endtask

   task automatic test_setup_drop;
      a_req_valid = 1'b1; a_req_addr = 24'h000600;
      @(negedge clk);
      a_req_valid = 1'b0;
      checks++;
      if (flash_do_read !== 1'b1) begin errors++; $display("FAIL sd_issue: got %b expected 1", flash_do_read); end
      flash_setup_done = 1'b0;
      @(negedge clk);
      checks++;
      if ({flash_do_read, a_rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
         errors++; $display("FAIL sd_rsp: got %b %b %b %h expected 0 1 1 ff", flash_do_read, a_rsp_valid, rsp_err, rsp_data);
      end
      @(negedge clk);
      a_req_valid = 1'b1; a_req_addr = 24'h000610; #1;
      checks++;
      if (busy !== 1'b1 || a_req_ready !== 1'b0) begin errors++; $display("FAIL sd_blocked: got busy=%b rdy=%b expected 1 0", busy, a_req_ready); end
      @(negedge clk); #1;
      checks++;
      if (a_req_ready !== 1'b0) begin errors++; $display("FAIL sd_still_blocked: got %b expected 0", a_req_ready); end
      flash_setup_done = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (a_req_ready !== 1'b1) begin errors++; $display("FAIL sd_resume: got %b expected 1", a_req_ready); end
      @(negedge clk);
      a_req_valid = 1'b0;
      finish_read(8'h66);
      checks++;
      if ({a_rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h66}) begin errors++; $display("FAIL sd_read: got %b %b %h expected 1 0 66", a_rsp_valid, rsp_err, rsp_data); end
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      a_req_valid = 1'b1; a_req_addr = 24'h000700;
      @(negedge clk);
      a_req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({flash_do_read, busy, a_rsp_valid, b_rsp_valid, flash_addr} !== '0) begin
         errors++; $display("FAIL ar_async: got %b %b %b %b %h expected all 0", flash_do_read, busy, a_rsp_valid, b_rsp_valid, flash_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_no_rsp: got rsp=%b busy=%b expected 0 0", a_rsp_valid, busy); end
      a_req_valid = 1'b1;
      @(negedge clk);
      a_req_valid = 1'b0;
      checks++;
      if (flash_do_read !== 1'b1 || flash_addr !== 24'h000700) begin errors++; $display("FAIL ar_reread: got %b %h expected 1 000700", flash_do_read, flash_addr); end
      finish_read(8'h70);
      checks++;
      if (a_rsp_valid !== 1'b1 || rsp_data !== 8'h70) begin errors++; $display("FAIL ar_rsp: got %b %h expected 1 70", a_rsp_valid, rsp_data); end
      @(negedge clk);
   endtask

`ifdef FLASH_ARB_CACHE_EN
   task automatic test_cache;
      a_req_valid = 1'b1; a_req_addr = 24'h000123;
      @(negedge clk);
      a_req_valid = 1'b0;
      finish_read(8'hC3);
      @(negedge clk);
      b_req_valid = 1'b1; b_req_addr = 24'h000123; #1;
      checks++;
      if (b_req_ready !== 1'b1) begin errors++; $display("FAIL cache_grant: got %b expected 1", b_req_ready); end
      @(negedge clk);
      b_req_valid = 1'b0;
      checks++;
      if ({b_rsp_valid, rsp_data, rsp_err, flash_do_read} !== {1'b1, 8'hC3, 1'b0, 1'b0}) begin
         errors++; $display("FAIL cache_hit: got %b %h %b %b expected 1 c3 0 0", b_rsp_valid, rsp_data, rsp_err, flash_do_read);
      end
      @(negedge clk);
      a_req_valid = 1'b1; a_req_addr = 24'h000456;
      @(negedge clk);
      a_req_valid = 1'b0;
      for (int i = 0; i < 20 && flash_do_read === 1'b1; i++) @(negedge clk);
      checks++;
      if (rsp_err !== 1'b1) begin errors++; $display("FAIL cache_to: got %b expected 1", rsp_err); end
      @(negedge clk);
      a_req_valid = 1'b1; a_req_addr = 24'h000123;
      @(negedge clk);
      a_req_valid = 1'b0;
      checks++;
      if (flash_do_read !== 1'b1) begin errors++; $display("FAIL cache_inval: got %b expected 1", flash_do_read); end
      finish_read(8'hC4);
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_setup_and_read();
      test_round_robin();
      test_timeout();
      test_setup_drop();
      test_async_reset();
`ifdef FLASH_ARB_CACHE_EN
      test_cache();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
